pad_stream_gen: RTL
===================

# pad_stream_gen

Frame source for the first convolution stage. Accepts an unpadded IMG_W×IMG_H 8-bit pixel stream from upstream over a valid/ready handshake. Inserts PADDING rows and columns of zeros on all four sides. Emits the full (IMG_W+2·PADDING)×(IMG_H+2·PADDING) raster as a valid-qualified stream, matching the padded-stream input of conv2d_layer1. One frame is streamed per `start` command.

## Interface
- IMG_W, 28, unpadded image width in pixels
- IMG_H, 28, unpadded image height in pixels
- PADDING, 1, zero border width on each side (0..3)
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a frame; sampled only in IDLE
- abort  input  1  synchronous cancel of the current frame
- s_valid  input  1  upstream pixel valid
- s_data  input  8  upstream pixel, unsigned
- s_ready  output  1  upstream pixel accepted when s_valid && s_ready; combinational
- out_valid  output  1  registered beat strobe to the conv stage
- out_data  output  8  registered padded pixel
- busy  output  1  high while state ≠ IDLE
- frame_done  output  1  one-cycle pulse coincident with the final beat of a frame

## Operation
- TOTAL_W = IMG_W+2·PADDING and TOTAL_H = IMG_H+2·PADDING.
- Counters: col in 0..TOTAL_W-1 and row in 0..TOTAL_H-1, each sized $clog2(TOTAL)+1.
- Interior means PADDING ≤ col < IMG_W+PADDING and PADDING ≤ row < IMG_H+PADDING.
- States: IDLE and STREAM.
  - IDLE → STREAM on `start`, with col = row = 0.
  - STREAM → IDLE after the last beat (row = TOTAL_H-1, col = TOTAL_W-1) or on `abort`.
- Padding position in STREAM: emit a beat (out_valid = 1, out_data = 0) and advance. Upstream is not consulted; s_ready = 0.
- Interior position in STREAM: s_ready = 1.
  - If s_valid is high, emit a beat with out_data = s_data and advance.
  - If s_valid is low, stall: out_valid = 0 and the counters hold.
- Advance rule: col increments. At TOTAL_W-1, col wraps to 0 and row increments.
- frame_done is registered and goes high together with the beat for the final position. The FSM is back in IDLE after that same edge.
- `start` is ignored while busy.
- `abort` takes priority over everything in STREAM. On abort:
  - state goes to IDLE and the counters clear;
  - out_valid goes to 0 on the next edge;
  - no frame_done is generated;
  - any pixel presented in the abort cycle is not accepted (s_ready is forced to 0 when abort is high).
- s_ready is 0 in IDLE. Upstream pixels are never dropped, and never duplicated within a frame.
- Exactly IMG_W·IMG_H pixels are accepted and TOTAL_W·TOTAL_H beats are emitted per completed frame.

## Timing
- Reset values: state IDLE, col = row = 0, out_valid = 0, out_data = 0, frame_done = 0, busy = 0, s_ready = 0.
- Latency is one cycle from acceptance to output: a pixel accepted at edge n appears on out_data after edge n.
- Suppose `start` is sampled at edge k and s_valid is held high. Then:
  - first beat (zero) is visible after edge k+1;
  - last beat plus frame_done are visible after edge k+TOTAL_W·TOTAL_H;
  - busy is low after that same edge.
- The earliest next `start` is sampled at edge k+TOTAL_W·TOTAL_H+1. The conv stage therefore sees at least one idle cycle between frames.
- When out_valid = 0, out_data holds its last value. It is not forced to zero.
- Mid-frame reset: all outputs return to their reset values immediately. The partial frame is discarded.

## Test plan
- Defaults, continuous s_valid with pixels 1..784 (mod 256), `start` at edge 0 → 900 beats on edges 1..900.
  - Beats 0..30 are zero and beat 31 = 1.
  - Row r, col c carries pixel (r-1)·28+(c-1) for interior positions and zero elsewhere.
  - frame_done coincides only with beat 900, and busy drops at edge 900.
- s_valid deasserted for 5 cycles at pixel 100 → out_valid is low for exactly those 5 cycles and s_ready stays high.
  - Frame completes 5 cycles later with an identical data sequence.
  - Padding beats are never stalled by s_valid = 0.
- `start` pulsed at edge 300 mid-frame → ignored.
  - Second `start` at edge 901 → second frame identical, first beat at edge 902.
- `abort` at edge 450 with s_valid high → s_ready = 0 that cycle and out_valid = 0 from edge 451.
  - busy = 0 and no frame_done.
  - Next frame starts clean at col = row = 0.
- IMG_W = 4, IMG_H = 3, PADDING = 2 → 8×7 = 56 beats and 12 accepted pixels.
  - First interior beat at position (2,2) = beat index 18.
- rst_n low at edge 200 → all outputs zero asynchronously.
  - After release, `start` yields a full correct 900-beat frame.

Source files
------------

// File: rtl/pad_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pad_stream_gen_if
// Description : Control and stream bundle for pad_stream_gen. It carries the
//               frame start/abort controls, the upstream valid/ready pixel
//               stream and the padded output stream to the conv stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pad_stream_gen_if;

  logic       start;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       frame_done;

  // Frame requester and pixel source side
  modport master (
    output start,
    output abort,
    output s_valid,
    output s_data,
    input  s_ready,
    input  out_valid,
    input  out_data,
    input  busy,
    input  frame_done
  );

  // Padding generator side
  modport slave (
    input  start,
    input  abort,
    input  s_valid,
    input  s_data,
    output s_ready,
    output out_valid,
    output out_data,
    output busy,
    output frame_done
  );

endinterface
`default_nettype wire

// File: rtl/pad_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : pad_stream_gen
// Description : Frame source for the first convolution stage. It takes an
//               unpadded IMG_W x IMG_H pixel stream and emits the raster with
//               a PADDING-wide zero border on all four sides. One frame is
//               produced per start command.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_stream_gen #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int PADDING = 1
) (
  input  wire             clk,
  input  wire             rst_n,
  pad_stream_gen_if.slave bus
);

  // Padded raster geometry and counter sizing
  localparam int c_TOTAL_W = IMG_W + 2 * PADDING;
  localparam int c_TOTAL_H = IMG_H + 2 * PADDING;
  localparam int c_COL_W   = $clog2(c_TOTAL_W) + 1;
  localparam int c_ROW_W   = $clog2(c_TOTAL_H) + 1;

  // Interior window bounds (inclusive low, exclusive high) and wrap points
  localparam logic [c_COL_W-1:0] c_COL_LO   = c_COL_W'(PADDING);
  localparam logic [c_COL_W-1:0] c_COL_HI   = c_COL_W'(IMG_W + PADDING);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(c_TOTAL_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LO   = c_ROW_W'(PADDING);
  localparam logic [c_ROW_W-1:0] c_ROW_HI   = c_ROW_W'(IMG_H + PADDING);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(c_TOTAL_H - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_frame_done;

  logic w_col_int;
  logic w_row_int;
  logic w_interior;
  logic w_active;
  logic w_beat;
  logic w_last;

  // Classify the current raster position and decide whether a beat fires.
  // Abort masks everything so no pixel is taken and no beat is produced.
  always_comb begin
    w_col_int  = (r_col >= c_COL_LO) && (r_col < c_COL_HI);
    w_row_int  = (r_row >= c_ROW_LO) && (r_row < c_ROW_HI);
    w_interior = w_col_int && w_row_int;
    w_active   = (r_state == ST_STREAM) && !bus.abort;
    // Border positions never wait on upstream; interior ones need a pixel.
    w_beat     = w_active && (!w_interior || bus.s_valid);
    w_last     = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
  end

  // Upstream is only asked for data at interior positions of a live frame
  assign bus.s_ready    = w_active && w_interior;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != ST_IDLE);

  // Frame sequencing, raster position counters and the registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      // Strobes are single-cycle; out_data deliberately keeps its last value
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_STREAM;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        ST_STREAM: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
          end else if (w_beat) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_interior ? bus.s_data : 8'd0;
            if (w_last) begin
              // Final beat: flag it and return to IDLE on the same edge
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
              r_col        <= '0;
              r_row        <= '0;
            end else if (r_col == c_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + c_ROW_W'(1);
            end else begin
              r_col <= r_col + c_COL_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
